title_loader: RTL and testbench
===============================

Name: title_loader

Overview:
- Byte-stream parser that builds the three 10-character title strings shown by the VGA text display and holds them as stable registers.
- Sits between the UART/optical receive path (byte valid/ready source) and the display's titles[2:0] input.
- Validates framed title updates, normalises characters to the 64-glyph font range (U+0020..U+005F), and commits each update atomically at a frame boundary so a title never changes mid-scanout.

Parameters:
- NCHAR, 10, characters per title (titles are NCHAR*8 bits wide)
- NSLOT, 3, number of title slots
- TIMEOUT, 1_000_000, maximum clk_pix cycles allowed between accepted bytes inside a frame
- STX, 8'h02, frame start byte

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst_pix  in  1  reset, asynchronous, active-high
- in_data  in  8  received byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte; transfer when in_valid && in_ready
- commit_en  in  1  start-of-video-frame pulse; tie high for immediate commit
- titles  out  [NCHAR*8-1:0] x NSLOT  title registers; first received character is in bits [79:72], last in [7:0]
- load_ok  out  1  one-cycle pulse when a title is committed
- load_err  out  1  one-cycle pulse when a frame is rejected
- err_code  out  2  reason for the last rejection: 1 = bad slot, 2 = checksum, 3 = timeout; holds until the next rejection
- busy  out  1  high in any state other than IDLE

Behaviour:
- Frame format: STX, slot byte (8'h30 + k, k < NSLOT), NCHAR character bytes, checksum byte.
  - Checksum = XOR of the slot byte and all NCHAR raw character bytes, taken before normalisation.
- Reset (async assert):
  - titles all 8'h20 (spaces)
  - state IDLE; in_ready 1
  - load_ok, load_err, busy 0; err_code 0
  - shadow buffer and counters cleared
- IDLE: a byte equal to STX moves to SLOT; all other bytes are accepted and discarded.
- SLOT:
  - Valid slot: latch k, clear the char index and running XOR, move to CHARS.
  - Invalid slot (not STX): load_err, err_code 1, back to IDLE.
- CHARS: each accepted byte is normalised and written to shadow[index]; index increments; the raw byte is XORed into the checksum. After the NCHAR-th byte, move to CSUM.
- Normalisation:
  - 8'h61..8'h7A: subtract 8'h20 (upper-case).
  - 8'h20..8'h5F: unchanged.
  - All other values: 8'h3F ('?').
- CSUM:
  - Checksum match: move to PEND.
  - Mismatch: load_err, err_code 2, back to IDLE; the target title is unchanged.
- PEND:
  - in_ready 0.
  - On the first cycle with commit_en high: copy shadow into titles[k], pulse load_ok, return to IDLE.
  - If commit_en is high on the cycle PEND is entered, the commit happens in that cycle, so titles updates 1 cycle after the checksum byte is accepted.
- STX received in SLOT or CHARS: resynchronise to SLOT without raising an error. STX in CSUM is treated as a checksum value.
- Timeout:
  - A counter runs in SLOT/CHARS/CSUM and resets on every accepted byte.
  - Reaching TIMEOUT: load_err, err_code 3, back to IDLE.
  - Not active in PEND or IDLE.
- Registered outputs: load_ok and load_err are registered and never high together. titles changes only on a commit cycle, and all NCHAR bytes of a slot change on the same edge.
- Reset asserted mid-frame or in PEND: the partial or pending frame is discarded and titles returns to spaces.
- in_ready is combinational from state only (0 only in PEND). It does not depend on in_valid.

Test Plan:
- Reset, no input -> titles[0..2] = 80'h2020…20, in_ready = 1, busy = 0.
- commit_en tied 1; send 02 31 "HELLO WORLD"[0:9] = 48 45 4C 4C 4F 20 57 4F 52 4C, checksum = XOR(0x31, chars) -> titles[1] = 80'h48454C4C4F20574F524C, load_ok pulses once, titles[0] and titles[2] remain spaces.
- Same frame sent to slot 0 with lowercase "hello" and byte 0x7E -> 'H','E','L','L','O', and 0x3F stored in place of 0x7E. The checksum is computed on the raw bytes; load_ok pulses.
- Correct frame with the checksum byte XORed with 0x01 -> load_err, err_code = 2, titles unchanged. Slot byte 0x33 -> err_code 1 immediately after the slot byte.
- commit_en held 0 after a valid frame -> in_ready = 0, titles unchanged for 1000 cycles. A single commit_en pulse -> titles updates on that edge and in_ready returns to 1.
- TIMEOUT = 16; send STX, slot, 3 chars, then idle 16 cycles -> load_err, err_code = 3, state IDLE. A following complete frame is then accepted normally.

Source files
------------

// File: rtl/title_loader_if.sv
// Byte-stream handshake between a receive source and the title loader.
//   in_data  : received byte (source -> loader)
//   in_valid : in_data is valid (source -> loader)
//   in_ready : loader can accept a byte (loader -> source)
// A byte transfers on a clock edge where in_valid && in_ready.
interface title_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/title_loader.sv
// Parses framed title updates from a byte stream and holds NSLOT titles of
// NCHAR characters each as stable registers for the text display.
// Frame: STX, slot byte (0x30+k), NCHAR chars, XOR checksum (slot ^ raw chars).
// Characters are folded into the 0x20..0x5F font range; a verified frame is
// copied into its title on a cycle where commit_en is high.
// Ports:
//   clk_pix, rst_pix : clock, asynchronous active-high reset
//   rx               : byte stream (in_data / in_valid / in_ready)
//   commit_en        : frame-boundary commit strobe (tie high for immediate)
//   titles           : title registers, first char in the top byte
//   load_ok/load_err : one-cycle registered result pulses
//   err_code         : last rejection reason (1 slot, 2 checksum, 3 timeout)
//   busy             : loader is not idle
module title_loader #(
  parameter int         NCHAR   = 10,
  parameter int         NSLOT   = 3,
  parameter int         TIMEOUT = 1_000_000,
  parameter logic [7:0] STX     = 8'h02
) (
  input  logic                              clk_pix,
  input  logic                              rst_pix,
  title_loader_if.slave                     rx,
  input  logic                              commit_en,
  output logic [NSLOT-1:0][NCHAR*8-1:0]     titles,
  output logic                              load_ok,
  output logic                              load_err,
  output logic [1:0]                        err_code,
  output logic                              busy
);

  localparam int IDX_W  = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SLOT, CHARS, CSUM, PEND} state_t;

  state_t                    state, state_nxt;
  logic [NCHAR-1:0][7:0]     shadow;
  logic [IDX_W-1:0]          idx;
  logic [7:0]                csum;
  logic [SLOT_W-1:0]         slot;
  logic [TMO_W-1:0]          tmo_cnt;

  logic                      accept;
  logic [7:0]                slot_off;
  logic                      slot_ok;
  logic                      tmo_hit;
  logic                      start, wr, commit;
  logic                      ok_nxt, err_nxt;
  logic [1:0]                code_nxt;

  function automatic logic [7:0] norm(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    else if (b >= 8'h20 && b <= 8'h5F) return b;
    else return 8'h3F;
  endfunction

  assign rx.in_ready = (state != PEND);
  assign busy        = (state != IDLE);
  assign accept      = rx.in_valid && rx.in_ready;
  // Offset wraps for bytes below 0x30, so one unsigned compare covers both ends.
  assign slot_off    = rx.in_data - 8'h30;
  assign slot_ok     = (slot_off < 8'(NSLOT));
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    wr        = 1'b0;
    commit    = 1'b0;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    case (state)
      IDLE: begin
        if (accept && rx.in_data == STX) state_nxt = SLOT;
      end
      SLOT: begin
        if (accept) begin
          if (rx.in_data == STX) begin
            state_nxt = SLOT;
          end else if (slot_ok) begin
            start     = 1'b1;
            state_nxt = CHARS;
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd1;
            state_nxt = IDLE;
          end
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          code_nxt  = 2'd3;
          state_nxt = IDLE;
        end
      end
      CHARS: begin
        if (accept) begin
          if (rx.in_data == STX) begin
            state_nxt = SLOT;
          end else begin
            wr = 1'b1;
            if (idx == IDX_W'(NCHAR - 1)) state_nxt = CSUM;
          end
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          code_nxt  = 2'd3;
          state_nxt = IDLE;
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx.in_data == csum) begin
            state_nxt = PEND;
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd2;
            state_nxt = IDLE;
          end
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          code_nxt  = 2'd3;
          state_nxt = IDLE;
        end
      end
      PEND: begin
        if (commit_en) begin
          commit    = 1'b1;
          ok_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      titles   <= {(NSLOT * NCHAR){8'h20}};
      shadow   <= '0;
      idx      <= '0;
      csum     <= '0;
      slot     <= '0;
      tmo_cnt  <= '0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
      err_code <= 2'd0;
    end else begin
      load_ok  <= ok_nxt;
      load_err <= err_nxt;
      err_code <= code_nxt;
      if (start) begin
        slot <= slot_off[SLOT_W-1:0];
        idx  <= '0;
        csum <= rx.in_data;
      end
      // Index 0 is the first character; it lands in the top byte of the title.
      if (wr) begin
        shadow[IDX_W'(NCHAR - 1) - idx] <= norm(rx.in_data);
        idx  <= idx + IDX_W'(1);
        csum <= csum ^ rx.in_data;
      end
      if (commit) titles[slot] <= shadow;
      // Idle-gap counter only runs while a frame is being received.
      if (accept || state_nxt == IDLE || state_nxt == PEND) tmo_cnt <= '0;
      else                                                   tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_title_loader.sv
module tb_title_loader;

  localparam logic [79:0] SP    = {10{8'h20}};
  localparam logic [79:0] HELLO = 80'h48454C4C4F20574F524C;
  localparam logic [79:0] LOWER = 80'h68656C6C6F7E574F524C;
  localparam logic [79:0] LOWN  = 80'h48454C4C4F3F574F524C;
  localparam logic [79:0] EDGE  = 80'h1F205F60617A7B80FF41;
  localparam logic [79:0] EDGEN = 80'h3F205F3F415A3F3F3F41;

  logic clk = 1'b0;
  logic rst;
  logic commit_en;
  logic [2:0][79:0] titles;
  logic load_ok, load_err, busy;
  logic [1:0] err_code;

  title_loader_if rx_if ();

  title_loader #(.NCHAR(10), .NSLOT(3), .TIMEOUT(16), .STX(8'h02)) dut (
    .clk_pix  (clk),
    .rst_pix  (rst),
    .rx       (rx_if.slave),
    .commit_en(commit_en),
    .titles   (titles),
    .load_ok  (load_ok),
    .load_err (load_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ok;
    logic [1:0]  code;
    int          slot;
    logic [79:0] title;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ok(input int s, input logic [79:0] t);
    exp_t e;
    e.is_ok = 1'b1; e.code = 2'd0; e.slot = s; e.title = t;
    q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_ok = 1'b0; e.code = c; e.slot = 0; e.title = '0;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (load_ok && load_err) check("ok_err_exclusive", 80'(1), 80'(0));
      if (load_ok || load_err) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {78'd0, load_ok, load_err}, 80'd0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", 80'(load_ok), 80'(e.is_ok));
          if (e.is_ok) check($sformatf("title_%0d", e.slot), titles[e.slot], e.title);
          else         check("err_code", 80'(err_code), 80'(e.code));
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_if.in_data  = b;
    rx_if.in_valid = 1'b1;
    while (!rx_if.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_if.in_ready) check("in_ready_wait", 80'(0), 80'(1));
    @(posedge clk);
    #1;
    rx_if.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] sb, input logic [79:0] ch, input logic [7:0] cs);
    send_byte(8'h02);
    send_byte(sb);
    for (int i = 0; i < 10; i++) send_byte(ch[79-8*i -: 8]);
    send_byte(cs);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({"drain_", name}, 80'(q.size()), 80'(0));
  endtask

  initial begin
    logic bad;
    logic [79:0] t0;
    rst = 1'b1;
    commit_en = 1'b1;
    rx_if.in_data = 8'h00;
    rx_if.in_valid = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_titles", titles[0] ^ titles[1] ^ titles[2], SP);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_title0", titles[0], SP);
    check("reset_title1", titles[1], SP);
    check("reset_title2", titles[2], SP);
    check("reset_in_ready", 80'(rx_if.in_ready), 80'(1));
    check("reset_busy", 80'(busy), 80'(0));
    check("reset_pulses", {78'd0, load_ok, load_err}, 80'd0);
    check("reset_err_code", 80'(err_code), 80'(0));

    // Leading garbage in IDLE is discarded; then HELLO WORLD to slot 1.
    send_byte(8'h41);
    send_byte(8'h31);
    push_ok(1, HELLO);
    send_frame(8'h31, HELLO, 8'h55);
    drain("hello");
    check("hello_title0", titles[0], SP);
    check("hello_title2", titles[2], SP);

    // Lower case and 0x7E folded; checksum over raw bytes.
    push_ok(0, LOWN);
    send_frame(8'h30, LOWER, 8'h2A);
    drain("lower");

    // Checksum wrong by one bit.
    push_err(2'd2);
    send_frame(8'h31, HELLO, 8'h54);
    drain("bad_csum");
    check("bad_csum_title1", titles[1], HELLO);

    // Slot out of range rejects right after the slot byte.
    push_err(2'd1);
    send_byte(8'h02);
    send_byte(8'h33);
    drain("bad_slot");
    check("bad_slot_busy", 80'(busy), 80'(0));

    // STX mid-frame resyncs; normalisation boundary values to slot 2.
    push_ok(2, EDGEN);
    send_byte(8'h02);
    send_byte(8'h32);
    send_byte(8'h41);
    send_byte(8'h42);
    send_frame(8'h32, EDGE, 8'h6C);
    drain("edge");

    // Commit held off: frame waits in PEND with in_ready low.
    commit_en = 1'b0;
    send_frame(8'h30, HELLO, 8'h54);
    t0 = titles[0];
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (rx_if.in_ready !== 1'b0 || titles[0] !== t0) bad = 1'b1;
    end
    check("pend_hold", 80'(bad), 80'(0));
    check("pend_title0", titles[0], LOWN);
    check("pend_busy", 80'(busy), 80'(1));
    push_ok(0, HELLO);
    commit_en = 1'b1;
    @(negedge clk);
    commit_en = 1'b0;
    check("post_commit_ready", 80'(rx_if.in_ready), 80'(1));
    drain("pend");
    commit_en = 1'b1;

    // Stall mid-frame for the timeout.
    push_err(2'd3);
    send_byte(8'h02);
    send_byte(8'h31);
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    drain("timeout");
    check("timeout_busy", 80'(busy), 80'(0));
    check("timeout_title1", titles[1], HELLO);
    push_ok(2, HELLO);
    send_frame(8'h32, HELLO, 8'h56);
    drain("after_timeout");

    // Reset in the middle of a frame restores spaces.
    send_byte(8'h02);
    send_byte(8'h30);
    send_byte(8'h41);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_title0", titles[0], SP);
    check("midrst_title2", titles[2], SP);
    check("midrst_busy", 80'(busy), 80'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("final_queue", 80'(q.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
